// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Control FSM for an 8-bit serial AES-128 encryption datapath. It accepts a
// start request, counts 16 plaintext bytes through the initial AddRoundKey
// (round 0), then steps the byte-serial datapath through rounds 1..NR at one
// byte slot per cycle. It also generates the per-slot strobes for the
// ShiftRows permutator, the MixColumns accumulator and the serializer. The
// ciphertext bytes are flagged on out_valid.
//
// Parameters
//   NR        number of cipher rounds after the initial key add
//   OUT_LAT   cycles from a final-round byte slot to its ciphertext on d_out
//   PLD_PHASE byte_idx[1:0] value at which pld asserts within a column
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   start      begin a block (honoured only in IDLE)
//   in_valid   plaintext byte present on the datapath input this cycle
//   in_ready   sequencer accepting plaintext bytes (LOAD)
//   busy       block in progress, through the done cycle
//   pld        parallel load of the MixColumns result into the serializer
//   c3         ShiftRows permutator control
//   mc_en      MixColumns enables ([3:0] byte lane, [4] accumulator clear)
//   round      current round, 0..NR
//   byte_idx   byte slot within the round, 0..15
//   rk_last    selects the last-round key path (round NR)
//   out_valid  ciphertext byte valid on d_out
//   done       one-cycle pulse after the last ciphertext byte
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
  parameter int NR        = 10,
  parameter int OUT_LAT   = 0,
  parameter int PLD_PHASE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       pld,
  output logic [1:0] c3,
  output logic [7:0] mc_en,
  output logic [3:0] round,
  output logic [3:0] byte_idx,
  output logic       rk_last,
  output logic       out_valid,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DRAIN} state_t;

  localparam logic [3:0] NR_L     = 4'(NR);
  localparam logic [1:0] PLD_L    = 2'(PLD_PHASE);
  // Last DRAIN count; unreachable when OUT_LAT is 0.
  localparam logic [7:0] CNT_LAST = 8'(OUT_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  logic       busy_q, busy_d;
  logic       in_ready_q, in_ready_d;
  logic       pld_q, pld_d;
  logic [1:0] c3_q, c3_d;
  logic [7:0] mc_en_q, mc_en_d;
  logic       rk_last_q, rk_last_d;
  // Marks a final-round byte slot; out_valid is this delayed by OUT_LAT.
  logic       fin_q, fin_d;

  // Strobe decode: every registered strobe is computed from the next-state
  // values so it lines up with the byte slot it describes.
  function automatic logic [7:0] mc_en_f(input state_t st, input logic [3:0] rnd,
                                         input logic [3:0] idx);
    mc_en_f = 8'h00;
    if (st == ROUND && rnd != NR_L)
      mc_en_f = {3'b000, (idx[1:0] == 2'b00), 4'b0001 << idx[1:0]};
  endfunction

  function automatic logic pld_f(input state_t st, input logic [3:0] rnd,
                                 input logic [3:0] idx);
    pld_f = (st == ROUND) && (rnd != NR_L) && (idx[1:0] == PLD_L);
  endfunction

  function automatic logic [1:0] c3_f(input state_t st, input logic [3:0] idx);
    c3_f = (st == LOAD || st == ROUND) ? idx[1:0] : 2'b00;
  endfunction

  // Next-state logic
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // The done cycle is still part of the finished block, so a start
        // arriving with done is dropped.
        if (start && !done_q) begin
          state_d = LOAD;
          round_d = 4'd0;
          idx_d   = 4'd0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (idx_q == 4'd15) begin
            state_d = ROUND;
            round_d = 4'd1;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ROUND: begin
        if (idx_q == 4'd15) begin
          idx_d = 4'd0;
          if (round_q == NR_L) begin
            round_d = 4'd0;
            cnt_d   = 8'd0;
            if (OUT_LAT > 0) begin
              state_d = DRAIN;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            round_d = round_q + 4'd1;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d     = (state_d != IDLE) || done_d;
    in_ready_d = (state_d == LOAD);
    pld_d      = pld_f(state_d, round_d, idx_d);
    c3_d       = c3_f(state_d, idx_d);
    mc_en_d    = mc_en_f(state_d, round_d, idx_d);
    rk_last_d  = (state_d == ROUND) && (round_d == NR_L);
    fin_d      = (state_d == ROUND) && (round_d == NR_L);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      round_q    <= 4'd0;
      idx_q      <= 4'd0;
      cnt_q      <= 8'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      pld_q      <= 1'b0;
      c3_q       <= 2'b00;
      mc_en_q    <= 8'h00;
      rk_last_q  <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      pld_q      <= pld_d;
      c3_q       <= c3_d;
      mc_en_q    <= mc_en_d;
      rk_last_q  <= rk_last_d;
      fin_q      <= fin_d;
    end
  end

  // Ciphertext valid: final-round slot marker delayed by OUT_LAT
  if (OUT_LAT == 0) begin : g_nolat
    assign out_valid = fin_q;
  end else begin : g_lat
    logic [OUT_LAT-1:0] dly_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dly_q <= '0;
      end else begin
        dly_q[0] <= fin_q;
        for (int i = 1; i < OUT_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign out_valid = dly_q[OUT_LAT-1];
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign pld      = pld_q;
  // During a LOAD stall the permutator is parked: c3 only follows the slot
  // on cycles where a plaintext byte is actually accepted.
  assign c3       = (state_q == LOAD && !in_valid) ? 2'b00 : c3_q;
  assign mc_en    = mc_en_q;
  assign round    = round_q;
  assign byte_idx = idx_q;
  assign rk_last  = rk_last_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for aes_round_sequencer. dut0 uses NR=10, OUT_LAT=0; dut1 uses
// NR=10, OUT_LAT=2. Stimulus pushes expected snapshots (probes), ciphertext
// cycles and done cycles into queues; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, inv0 = 1'b0;
  logic       start1 = 1'b0, inv1 = 1'b0;

  logic       rdy0, busy0, pld0, rk0, ov0, dn0;
  logic [1:0] c3_0;
  logic [7:0] mc0;
  logic [3:0] rnd0, idx0;
  logic       rdy1, busy1, pld1, rk1, ov1, dn1;
  logic [1:0] c3_1;
  logic [7:0] mc1;
  logic [3:0] rnd1, idx1;

  aes_round_sequencer #(.NR(10), .OUT_LAT(0), .PLD_PHASE(3)) dut0 (
    .clk(clk), .rst(rst_n), .start(start0), .in_valid(inv0),
    .in_ready(rdy0), .busy(busy0), .pld(pld0), .c3(c3_0), .mc_en(mc0),
    .round(rnd0), .byte_idx(idx0), .rk_last(rk0), .out_valid(ov0), .done(dn0)
  );

  aes_round_sequencer #(.NR(10), .OUT_LAT(2), .PLD_PHASE(3)) dut1 (
    .clk(clk), .rst(rst_n), .start(start1), .in_valid(inv1),
    .in_ready(rdy1), .busy(busy1), .pld(pld1), .c3(c3_1), .mc_en(mc1),
    .round(rnd1), .byte_idx(idx1), .rk_last(rk1), .out_valid(ov1), .done(dn1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          dut;
    bit          ri;
    logic [23:0] exp;
  } probe_t;

  probe_t pq[$];
  int     ovq0[$], ovq1[$], dnq0[$], dnq1[$];
  int     tests = 0;
  int     fails = 0;
  bit     end_req = 1'b0;
  bit     fin_done = 1'b0;
  bit     cur_dut = 1'b0;
  int     base = 0;
  int     mc_tbl[8] = '{'h11, 'h02, 'h04, 'h08, 'h11, 'h02, 'h04, 'h08};

  // flags = {pld, rk_last, in_ready, busy, out_valid, done}
  task automatic pp(input int k, input int ri, input int rnd, input int idx,
                    input int c3, input int mc, input int flags);
    probe_t p;
    p.cyc = base + k;
    p.dut = cur_dut;
    p.ri  = (ri != 0);
    p.exp = {4'(rnd), 4'(idx), 2'(c3), 8'(mc), 6'(flags)};
    pq.push_back(p);
  endtask

  function automatic logic [23:0] act(input bit d);
    if (d) act = {rnd1, idx1, c3_1, mc1, pld1, rk1, rdy1, busy1, ov1, dn1};
    else   act = {rnd0, idx0, c3_0, mc0, pld0, rk0, rdy0, busy0, ov0, dn0};
  endfunction

  // Monitor / scoreboard
  probe_t      pm;
  logic [23:0] av, mask;
  int          e;
  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      pm   = pq.pop_front();
      av   = act(pm.dut);
      mask = pm.ri ? 24'hFFFFFF : 24'h00FFFF;
      tests++;
      if (pm.cyc != cyc || ((av ^ pm.exp) & mask) != 24'h0) begin
        fails++;
        $display("FAIL probe dut%0d cyc=%0d: got rnd=%0d idx=%0d c3=%0d mc=%02h f=%06b, want rnd=%0d idx=%0d c3=%0d mc=%02h f=%06b (ri=%0d)",
                 pm.dut, pm.cyc, av[23:20], av[19:16], av[15:14], av[13:6], av[5:0],
                 pm.exp[23:20], pm.exp[19:16], pm.exp[15:14], pm.exp[13:6], pm.exp[5:0], pm.ri);
      end
    end
    if (ov0) begin
      tests++;
      if (ovq0.size() == 0) begin
        fails++; $display("FAIL ov0_unexpected cyc=%0d: got out_valid=1, want 0", cyc);
      end else begin
        e = ovq0.pop_front();
        if (e != cyc) begin fails++; $display("FAIL ov0_cycle: got cyc=%0d, want %0d", cyc, e); end
      end
    end
    if (ov1) begin
      tests++;
      if (ovq1.size() == 0) begin
        fails++; $display("FAIL ov1_unexpected cyc=%0d: got out_valid=1, want 0", cyc);
      end else begin
        e = ovq1.pop_front();
        if (e != cyc) begin fails++; $display("FAIL ov1_cycle: got cyc=%0d, want %0d", cyc, e); end
      end
    end
    if (dn0) begin
      tests++;
      if (dnq0.size() == 0) begin
        fails++; $display("FAIL done0_unexpected cyc=%0d: got done=1, want 0", cyc);
      end else begin
        e = dnq0.pop_front();
        if (e != cyc) begin fails++; $display("FAIL done0_cycle: got cyc=%0d, want %0d", cyc, e); end
      end
    end
    if (dn1) begin
      tests++;
      if (dnq1.size() == 0) begin
        fails++; $display("FAIL done1_unexpected cyc=%0d: got done=1, want 0", cyc);
      end else begin
        e = dnq1.pop_front();
        if (e != cyc) begin fails++; $display("FAIL done1_cycle: got cyc=%0d, want %0d", cyc, e); end
      end
    end
    if (end_req && !fin_done) begin
      tests++;
      if (pq.size() + ovq0.size() + ovq1.size() + dnq0.size() + dnq1.size() != 0) begin
        fails++;
        $display("FAIL leftover: got pending probes=%0d ov0=%0d ov1=%0d done0=%0d done1=%0d, want all 0",
                 pq.size(), ovq0.size(), ovq1.size(), dnq0.size(), dnq1.size());
      end
      fin_done = 1'b1;
    end
  end

  task automatic set_in(input bit d, input logic st, input logic iv);
    if (d) begin start1 = st; inv1 = iv; end
    else   begin start0 = st; inv0 = iv; end
  endtask

  // Drives one block: cycle k = 0 is the start cycle (already set by caller).
  task automatic drive(input bit d, input int ncyc, input int st_lo, input int st_hi,
                       input int s1, input int s2, input int rst_k);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      set_in(d, (k == s1) || (k == s2), (k <= 30) && !(k >= st_lo && k <= st_hi));
      if (k == rst_k)     rst_n = 1'b0;
      if (k == rst_k + 3) rst_n = 1'b1;
    end
    @(posedge clk); #1;
    set_in(d, 1'b0, 1'b0);
  endtask

  task automatic begin_block(input bit d);
    @(posedge clk); #1;
    cur_dut = d;
    base    = cyc;
  endtask

  initial begin
    // Reset state
    base = 0; cur_dut = 1'b0;
    pp(1, 1, 0, 0, 0, 0, 'b000000);
    cur_dut = 1'b1;
    pp(1, 1, 0, 0, 0, 0, 'b000000);
    cur_dut = 1'b0;
    pp(2, 1, 0, 0, 0, 0, 'b000000);
    cur_dut = 1'b1;
    pp(2, 1, 0, 0, 0, 0, 'b000000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Reset asserted mid-round 5
    begin_block(1'b0);
    pp(84, 1, 5, 3, 3, 'h08, 'b100100);
    pp(85, 1, 5, 4, 0, 'h11, 'b000100);
    pp(86, 1, 0, 0, 0, 0, 'b000000);
    pp(87, 1, 0, 0, 0, 0, 'b000000);
    pp(90, 1, 0, 0, 0, 0, 'b000000);
    set_in(1'b0, 1'b1, 1'b1);
    drive(1'b0, 94, 1000, 0, -1, -1, 86);

    // Basic block: in_valid held, start while busy and on the done cycle
    begin_block(1'b0);
    pp(1, 1, 0, 0, 0, 0, 'b001100);
    pp(16, 1, 0, 15, 3, 0, 'b001100);
    for (int b = 0; b < 8; b++)
      pp(17 + b, 1, 1, b, b % 4, mc_tbl[b], ((b == 3 || b == 7) ? 'b100000 : 0) + 'b000100);
    for (int r = 2; r <= 9; r++) begin
      pp(17 + 16 * (r - 1), 1, r, 0, 0, 'h11, 'b000100);
      if (r == 3) pp(51, 1, 3, 2, 2, 'h04, 'b000100);
    end
    for (int b = 0; b < 16; b++) begin
      pp(161 + b, 1, 10, b, b % 4, 0, 'b010110);
      ovq0.push_back(base + 161 + b);
    end
    pp(177, 1, 0, 0, 0, 0, 'b000101);
    pp(178, 1, 0, 0, 0, 0, 'b000000);
    pp(179, 1, 0, 0, 0, 0, 'b000000);
    dnq0.push_back(base + 177);
    set_in(1'b0, 1'b1, 1'b1);
    drive(1'b0, 182, 1000, 0, 50, 177, -100);

    // LOAD stall: in_valid low for 5 cycles after byte 7
    begin_block(1'b0);
    pp(8, 1, 0, 7, 3, 0, 'b001100);
    for (int k = 9; k <= 13; k++) pp(k, 1, 0, 8, 0, 0, 'b001100);
    pp(14, 1, 0, 8, 0, 0, 'b001100);
    pp(15, 1, 0, 9, 1, 0, 'b001100);
    pp(21, 1, 0, 15, 3, 0, 'b001100);
    pp(22, 1, 1, 0, 0, 'h11, 'b000100);
    pp(166, 1, 10, 0, 0, 0, 'b010110);
    pp(182, 1, 0, 0, 0, 0, 'b000101);
    for (int b = 0; b < 16; b++) ovq0.push_back(base + 166 + b);
    dnq0.push_back(base + 182);
    set_in(1'b0, 1'b1, 1'b1);
    drive(1'b0, 186, 9, 13, -1, -1, -100);

    // OUT_LAT = 2 with DRAIN
    begin_block(1'b1);
    pp(1, 1, 0, 0, 0, 0, 'b001100);
    pp(161, 1, 10, 0, 0, 0, 'b010100);
    pp(162, 1, 10, 1, 1, 0, 'b010100);
    pp(163, 1, 10, 2, 2, 0, 'b010110);
    pp(176, 1, 10, 15, 3, 0, 'b010110);
    pp(177, 0, 0, 0, 0, 0, 'b000110);
    pp(178, 0, 0, 0, 0, 0, 'b000110);
    pp(179, 1, 0, 0, 0, 0, 'b000101);
    pp(180, 1, 0, 0, 0, 0, 'b000000);
    for (int b = 0; b < 16; b++) ovq1.push_back(base + 163 + b);
    dnq1.push_back(base + 179);
    set_in(1'b1, 1'b1, 1'b1);
    drive(1'b1, 184, 1000, 0, -1, -1, -100);

    repeat (2) @(posedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 20 && !fin_done; i++) @(posedge clk);
    if (!fin_done) begin
      fails++;
      $display("FAIL end_check: got monitor_finished=0, want 1");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time=%0t, want finish before it", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control FSM for the 8-bit serial AES-128 encryption datapath: byte-serial AddRoundKey, ShiftRows permutator, S-box, MixColumns accumulator, and parallel-load serializer.
- Accepts a start request and 16 plaintext bytes.
- Steps the datapath through rounds 0..NR, generating per-cycle strobes: pld, c3, mc_en, round index, last-key select.
- Flags the 16 ciphertext bytes on out_valid.

Parameters:
- NR, 10: number of cipher rounds after the initial key add.
- OUT_LAT, 0: cycles from a final-round byte slot to that ciphertext byte on d_out.
- PLD_PHASE, 3: byte_idx[1:0] value at which pld asserts within each column.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a block; sampled only in IDLE.
- in_valid  in  1  plaintext byte present on datapath d_in this cycle.
- in_ready  out  1  sequencer accepting plaintext bytes.
- busy  out  1  block in progress.
- pld  out  1  parallel load of MixColumns result into serializer.
- c3  out  2  permutator (ShiftRows) control.
- mc_en  out  8  MixColumns enables.
- round  out  4  current round, 0..NR.
- byte_idx  out  4  byte slot within round, 0..15.
- rk_last  out  1  selects last-round key path (round NR).
- out_valid  out  1  ciphertext byte valid on d_out.
- done  out  1  one-cycle pulse after the last ciphertext byte.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including in_ready.
  - round=0 and byte_idx=0.
  - Applies immediately, including mid-block; no partial output continues.
- States: IDLE, LOAD, ROUND, DRAIN.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> LOAD next cycle, round=0, byte_idx=0.
- LOAD (round 0, initial AddRoundKey):
  - in_ready=1, busy=1.
  - byte_idx increments only on cycles with in_valid=1.
  - in_valid=0 stalls: counters hold; pld=0, mc_en=0.
  - c3=byte_idx[1:0] on accepted cycles, else 0.
  - Accepted byte 15 -> ROUND, round=1, byte_idx=0.
- ROUND: no stalls; byte_idx increments every cycle, 15 wraps to 0 with round+1.
  - c3=byte_idx[1:0].
  - Rounds 1..NR-1:
    - mc_en[3:0]=one-hot(byte_idx[1:0]), e.g. byte_idx=6 -> 4'b0100.
    - mc_en[4]=1 when byte_idx[1:0]==0 (accumulator clear at column start).
    - mc_en[7:5]=0.
    - pld=1 when byte_idx[1:0]==PLD_PHASE.
  - Round NR:
    - mc_en=0, pld=0, rk_last=1.
    - Byte 15 of round NR -> DRAIN if OUT_LAT>0, else IDLE with done.
- out_valid:
  - High for exactly 16 consecutive cycles.
  - Equals (state==ROUND && round==NR) delayed by OUT_LAT cycles.
- DRAIN:
  - busy=1; waits OUT_LAT cycles for the delayed out_valid to finish.
  - Then -> IDLE.
- done:
  - Single-cycle pulse on the cycle after the last out_valid.
  - Concurrent with the transition to IDLE.
- busy: 1 from entry to LOAD through the cycle done pulses.
- Simultaneous events:
  - start while busy is ignored, not queued.
  - start on the same cycle done pulses is ignored; a new start must come in IDLE.
  - in_valid outside LOAD is ignored.
- Latency: start-to-done = 1 + (16 + load stall cycles) + 16*NR + OUT_LAT cycles.
- Registered outputs: pld, c3, mc_en, rk_last, round, and byte_idx are registered, and all are valid in the same cycle as the byte slot they describe.

Test Plan:
1. Reset then start, in_valid held high, NR=10, OUT_LAT=0:
   - LOAD lasts 16 cycles.
   - round steps 1..10 at 16-cycle intervals.
   - out_valid high for 16 cycles in round 10.
   - done pulses exactly 177 cycles after start.
2. Strobe check in round 1, byte_idx 0..7:
   - mc_en = 0x11,0x02,0x04,0x08,0x11,0x02,0x04,0x08.
   - pld high only at byte_idx 3 and 7.
   - c3 = 0,1,2,3,0,1,2,3.
3. Round 10:
   - rk_last=1, pld=0, mc_en=0 for all 16 cycles.
   - rk_last=0 in rounds 0..9.
4. in_valid deasserted for 5 cycles after byte 7 in LOAD:
   - byte_idx holds at 8, pld=0, mc_en=0.
   - done arrives 5 cycles later than in scenario 1 (182).
5. OUT_LAT=2:
   - out_valid starts 2 cycles after round 10 byte 0 and lasts 16 cycles.
   - busy stays high through DRAIN.
   - done pulses 179 cycles after start.
6. rst=0 asserted mid-round 5, and start pulsed while busy:
   - All outputs 0 immediately; state is IDLE.
   - A start while busy in a separate run has no effect on round or byte_idx.
